servo_motion_ctrl: RTL and testbench
====================================

// Module: servo_motion_ctrl
// PURPOSE
//  Motion sequencer for the hobby-servo PWM channel: accepts target angles (0..180 deg) over a
//  valid/ready handshake and ramps the commanded angle toward each target at a programmable
//  slew rate. Angle updates occur only at servo frame boundaries, so the PWM generator never
//  sees a mid-frame change. After arrival, dwells for HOLD_FRAMES frames, then pulses done.
//  Sits between the command source (switches/UART/host FSM) and the servo PWM generator.
// PARAMETERS
//  CLK_FREQ         5_000_000  system clock frequency, Hz
//  SERVO_FREQ       50         servo frame rate, Hz; frame length MAX_COUNT = CLK_FREQ/SERVO_FREQ
//  ANGLE_MAX        180        upper angle limit, degrees; commands above are clamped
//  INIT_ANGLE       90         angle value loaded at reset
//  STEP_DEG         2          max angle change per step, degrees (>=1)
//  FRAMES_PER_STEP  1          frame_ticks between angle steps (>=1)
//  HOLD_FRAMES      10         frame_ticks to dwell at target before done (0 allowed)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous, active-low reset
//  cmd_valid   in   1  target angle offered
//  cmd_angle   in   8  target angle, degrees, unsigned
//  cmd_ready   out  1  controller idle, will accept a command
//  abort       in   1  stop the current motion, freeze the angle
//  angle       out  8  commanded angle to the PWM generator, degrees
//  frame_tick  out  1  one-cycle pulse on the last clock of each servo frame
//  busy        out  1  high in MOVE or HOLD
//  done        out  1  one-cycle pulse when a move completes normally
// BEHAVIOUR
//  Reset (rst=0, async): angle=INIT_ANGLE, cmd_ready=1, busy=0, done=0, frame_tick=0,
//    state=IDLE, frame timer=0, step/hold counters=0. All outputs are registered.
//  Frame timer: free-running 0..MAX_COUNT-1, runs in every state. frame_tick=1 exactly when
//    timer==MAX_COUNT-1; wraps to 0 on the next cycle.
//  States: IDLE, MOVE, HOLD. busy = (state!=IDLE); cmd_ready = (state==IDLE).
//  IDLE: a handshake occurs when cmd_valid && cmd_ready at a clock edge. Target latched as
//    min(cmd_angle, ANGLE_MAX). Next state MOVE if target!=angle, else HOLD. cmd_ready drops on
//    the following cycle. abort is ignored in IDLE.
//  MOVE: a step counter counts frame_ticks. On the frame_tick that completes FRAMES_PER_STEP
//    ticks, angle moves toward the target by STEP_DEG, or lands exactly on the target if
//    |target-angle|<=STEP_DEG. There is never an overshoot or wrap-around. The step counter
//    clears on each step. When the updated angle equals the target, go to HOLD with the hold
//    counter at 0.
//  Arithmetic: use a 9-bit signed difference; angle always stays within 0..ANGLE_MAX.
//  HOLD: the hold counter counts frame_ticks. When it reaches HOLD_FRAMES (immediately if
//    HOLD_FRAMES=0), go to IDLE. done=1 and cmd_ready=1 on that same next cycle, for one cycle.
//  abort in MOVE/HOLD: next cycle state=IDLE, cmd_ready=1, done stays 0, angle keeps its current
//    value. abort takes priority over a step or hold expiry in the same cycle.
//  The frame timer is unaffected by commands and abort. Only rst restarts it.
//  cmd_valid while busy: not accepted. The source must hold the command until cmd_ready.
//  Reset mid-operation: immediate return to the reset values above. The in-flight target is lost.
// TESTING  (bench: CLK_FREQ=1000, SERVO_FREQ=50 -> 20 clk/frame; defaults otherwise)
//  1 Release reset -> angle=90, cmd_ready=1, busy=0; frame_tick pulses every 20 clk, 1 clk wide.
//  2 cmd 100 -> angle 92,94,96,98,100 on 5 consecutive frame_ticks; done after 10 more ticks,
//    with cmd_ready=1 on the same cycle as done.
//  3 cmd 95 from 90 -> 92,94,95 (no overshoot); cmd 200 -> target clamped, final angle=180.
//  4 abort after angle=94 during a move to 120 -> next cycle IDLE, angle holds 94, no done pulse;
//    a frame_tick coincident with abort causes no step.
//  5 cmd equal to current angle -> no angle change; done after exactly 10 frame_ticks.
//  6 rst low mid-MOVE -> async: angle=90, busy=0 immediately; cmd_valid while busy -> ignored.

Source files
------------

// File: rtl/servo_motion_ctrl_if.sv
// Command/status bundle between a motion command source and the servo motion sequencer.
`timescale 1ns/1ps
interface servo_motion_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_angle;
  logic       cmd_ready;
  logic       abort;
  logic [7:0] angle;
  logic       frame_tick;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_angle, abort,
    input  cmd_ready, angle, frame_tick, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_angle, abort,
    output cmd_ready, angle, frame_tick, busy, done
  );
endinterface

// File: rtl/servo_motion_ctrl.sv
// Servo motion sequencer: accepts target angles, slews the commanded angle toward the
// target one step per FRAMES_PER_STEP servo frames, dwells HOLD_FRAMES frames, pulses done.
`timescale 1ns/1ps
module servo_motion_ctrl #(
  parameter int unsigned CLK_FREQ        = 5_000_000,
  parameter int unsigned SERVO_FREQ      = 50,
  parameter int unsigned ANGLE_MAX       = 180,
  parameter int unsigned INIT_ANGLE      = 90,
  parameter int unsigned STEP_DEG        = 2,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned HOLD_FRAMES     = 10
) (
  input  logic              clk,
  input  logic              rst,
  servo_motion_ctrl_if.slave bus
);
  localparam int unsigned MAX_COUNT = CLK_FREQ / SERVO_FREQ;
  localparam int unsigned TW = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
  localparam int unsigned SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_COUNT - 1);
  localparam logic [TW-1:0] TIMER_PRE  = TW'(MAX_COUNT - 2);
  localparam logic [SW-1:0] STEP_LAST  = SW'(FRAMES_PER_STEP - 1);
  localparam logic [HW-1:0] HOLD_LAST  = (HOLD_FRAMES == 0) ? '0 : HW'(HOLD_FRAMES - 1);
  localparam logic [7:0]    AMAX       = 8'(ANGLE_MAX);
  localparam logic [7:0]    AINIT      = 8'(INIT_ANGLE);
  localparam logic [7:0]    STEP_U     = 8'(STEP_DEG);
  localparam logic signed [8:0] STEP_POS = 9'(STEP_DEG);
  localparam logic signed [8:0] STEP_NEG = -STEP_POS;

  typedef enum logic [1:0] {IDLE, MOVE, HOLD} state_t;

  state_t            state, state_d;
  logic [TW-1:0]     timer;
  logic              frame_tick_q;
  logic [7:0]        angle_q, angle_d;
  logic [7:0]        target_q, target_d;
  logic [SW-1:0]     step_cnt, step_d;
  logic [HW-1:0]     hold_cnt, hold_d;
  logic              cmd_ready_q, busy_q, done_q, done_d;
  logic [7:0]        cmd_clamped;
  logic signed [8:0] diff;
  logic [7:0]        step_angle;

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.angle      = angle_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Free-running frame timer; the tick is registered one count early so it lines up
  // with the last clock of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      timer        <= (timer == TIMER_LAST) ? '0 : timer + TW'(1);
      frame_tick_q <= (timer == TIMER_PRE);
    end
  end

  // Clamp of the incoming target and the next angle one slew step toward the target.
  always_comb begin
    cmd_clamped = (bus.cmd_angle > AMAX) ? AMAX : bus.cmd_angle;
    diff        = $signed({1'b0, target_q}) - $signed({1'b0, angle_q});
    if (diff > STEP_POS)
      step_angle = angle_q + STEP_U;
    else if (diff < STEP_NEG)
      step_angle = angle_q - STEP_U;
    else
      step_angle = target_q;
  end

  // Next-state logic: handshake in IDLE, stepping on frame ticks in MOVE, dwell in HOLD;
  // abort outranks a step or hold expiry in the same cycle.
  always_comb begin
    state_d  = state;
    angle_d  = angle_q;
    target_d = target_q;
    step_d   = step_cnt;
    hold_d   = hold_cnt;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          target_d = cmd_clamped;
          step_d   = '0;
          hold_d   = '0;
          state_d  = (cmd_clamped != angle_q) ? MOVE : HOLD;
        end
      end
      MOVE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (frame_tick_q) begin
          if (step_cnt == STEP_LAST) begin
            step_d  = '0;
            angle_d = step_angle;
            if (step_angle == target_q) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end else begin
            step_d = step_cnt + SW'(1);
          end
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (HOLD_FRAMES == 0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (frame_tick_q) begin
          if (hold_cnt == HOLD_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      angle_q     <= AINIT;
      target_q    <= AINIT;
      step_cnt    <= '0;
      hold_cnt    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      step_cnt    <= step_d;
      hold_cnt    <= hold_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Scoreboard bench for servo_motion_ctrl at 20 clocks per servo frame.
`timescale 1ns/1ps
module tb_servo_motion_ctrl;
  logic clk;
  logic rst;

  servo_motion_ctrl_if bus ();

  servo_motion_ctrl #(
    .CLK_FREQ   (1000),
    .SERVO_FREQ (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit is_done;
    int val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_angle(input int a);
    exp_t e;
    e.is_done = 1'b0;
    e.val     = a;
    sb.push_back(e);
  endtask

  task automatic push_done(input int ticks);
    exp_t e;
    e.is_done = 1'b1;
    e.val     = ticks;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every angle change and done pulse, and checks the frame period.
  int         prev_angle;
  bit         prev_busy;
  int         tick_cnt;
  int         cyc;
  bit         tick_seen;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_angle = int'(bus.angle);
      prev_busy  = 1'b0;
      tick_cnt   = 0;
      cyc        = 0;
      tick_seen  = 1'b0;
    end else begin
      cyc++;
      if (bus.busy && !prev_busy) tick_cnt = 0;
      if (int'(bus.angle) != prev_angle) begin
        tick_cnt = 0;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_angle: got %0d expected no change", bus.angle);
        end else begin
          e = sb.pop_front();
          chk("angle_event_kind", 0, int'(e.is_done));
          chk("angle_value", int'(bus.angle), e.val);
        end
      end
      if (bus.frame_tick) begin
        if (tick_seen) chk("frame_period", cyc, 20);
        tick_seen = 1'b1;
        cyc       = 0;
        tick_cnt++;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got 1 expected 0");
        end else begin
          e = sb.pop_front();
          chk("done_event_kind", 1, int'(e.is_done));
          chk("done_after_ticks", tick_cnt, e.val);
          chk("done_cmd_ready", int'(bus.cmd_ready), 1);
          chk("done_busy", int'(bus.busy), 0);
        end
      end
      prev_angle = int'(bus.angle);
      prev_busy  = bus.busy;
    end
  end

  task automatic send(input int a);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_angle = 8'(a);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < budget);
    if (!bus.done) chk("wait_done_timeout", 0, 1);
  endtask

  task automatic wait_angle(input int a, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(bus.angle) != a && n < budget);
    if (int'(bus.angle) != a) chk("wait_angle_timeout", int'(bus.angle), a);
  endtask

  // Directed stimulus; expected angle sequences and done timings are pushed before each command.
  initial begin
    int a;
    int n;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_angle = '0;
    bus.abort     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_angle", int'(bus.angle), 90);
    chk("reset_cmd_ready", int'(bus.cmd_ready), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_frame_tick", int'(bus.frame_tick), 0);
    rst = 1'b1;

    // 90 -> 100 in steps of 2, then 10-frame dwell
    for (int i = 92; i <= 100; i += 2) push_angle(i);
    push_done(10);
    send(100);
    wait_done(600);

    // Command equal to current angle: dwell only
    push_done(10);
    send(100);
    wait_done(600);

    // Back down to 90
    for (int i = 98; i >= 90; i -= 2) push_angle(i);
    push_done(10);
    send(90);
    wait_done(600);

    // 90 -> 95 lands exactly without overshoot
    push_angle(92);
    push_angle(94);
    push_angle(95);
    push_done(10);
    send(95);
    wait_done(600);

    // 200 clamps to 180
    a = 95;
    while (a < 180) begin
      a = (a + 2 > 180) ? 180 : a + 2;
      push_angle(a);
    end
    push_done(10);
    send(200);
    wait_done(2000);

    // Move toward 120; a command while busy is ignored; async reset mid-move
    push_angle(178);
    push_angle(176);
    send(120);
    wait_angle(178, 100);
    @(negedge clk);
    bus.cmd_angle = 8'd200;
    bus.cmd_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("busy_cmd_ready", int'(bus.cmd_ready), 0);
      chk("busy_busy", int'(bus.busy), 1);
    end
    bus.cmd_valid = 1'b0;
    wait_angle(176, 100);
    #3 rst = 1'b0;
    #1;
    chk("async_reset_angle", int'(bus.angle), 90);
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_cmd_ready", int'(bus.cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Abort coincident with a frame tick after reaching 94 on the way to 120
    push_angle(92);
    push_angle(94);
    send(120);
    wait_angle(94, 100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < 30);
    chk("abort_tick_found", int'(bus.frame_tick), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_angle", int'(bus.angle), 94);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_cmd_ready", int'(bus.cmd_ready), 1);
    chk("abort_done", int'(bus.done), 0);
    repeat (80) @(negedge clk);
    chk("abort_angle_frozen", int'(bus.angle), 94);

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #2000000;
    checks++;
    failures++;
    $display("FAIL global_timeout: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
